// File: rtl/watch_time_counter.sv
// Time-of-day core: synchronizes the 1 Hz divider output, keeps BCD hh:mm:ss (24 h),
// and supports a front-panel set mode that freezes time while minutes/hours are stepped.
module watch_time_counter #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] INIT_HH     = 8'h00,
  parameter logic [7:0] INIT_MM     = 8'h00
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       _1Hz_clk,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_tick,
  output logic       min_carry,
  output logic       day_pulse
);

  // BCD increment modulo 60 (used for both seconds and minutes).
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD increment modulo 24; 23 rolls to 00 before the ones digit reaches 9.
  function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [7:0]             r_hh;
  logic [7:0]             r_mm;
  logic [7:0]             r_ss;
  logic                   r_sec_tick;
  logic                   r_min_carry;
  logic                   r_day_pulse;

  logic w_tick;
  logic w_ss_wrap;
  logic w_mm_wrap;
  logic w_day_wrap;

  always_comb begin
    w_tick     = r_sync[SYNC_STAGES-1] & ~r_hist;
    w_ss_wrap  = (r_ss == 8'h59);
    w_mm_wrap  = (r_mm == 8'h59);
    w_day_wrap = (r_hh == 8'h23) & w_mm_wrap & w_ss_wrap;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_sync      <= '0;
      r_hist      <= 1'b0;
      r_hh        <= INIT_HH;
      r_mm        <= INIT_MM;
      r_ss        <= 8'h00;
      r_sec_tick  <= 1'b0;
      r_min_carry <= 1'b0;
      r_day_pulse <= 1'b0;
    end else begin
      // History keeps tracking in set mode so a held-high input cannot fire on exit.
      r_sync      <= {r_sync[SYNC_STAGES-2:0], _1Hz_clk};
      r_hist      <= r_sync[SYNC_STAGES-1];
      r_sec_tick  <= 1'b0;
      r_min_carry <= 1'b0;
      r_day_pulse <= 1'b0;
      if (set_mode) begin
        r_ss <= 8'h00;
        if (inc_min)  r_mm <= bcd_inc60(r_mm);
        if (inc_hour) r_hh <= bcd_inc24(r_hh);
      end else if (w_tick) begin
        r_ss        <= bcd_inc60(r_ss);
        r_sec_tick  <= 1'b1;
        r_day_pulse <= w_day_wrap;
        if (w_ss_wrap) begin
          r_min_carry <= 1'b1;
          r_mm        <= bcd_inc60(r_mm);
          if (w_mm_wrap) r_hh <= bcd_inc24(r_hh);
        end
      end
    end
  end

  assign hh        = r_hh;
  assign mm        = r_mm;
  assign ss        = r_ss;
  assign sec_tick  = r_sec_tick;
  assign min_carry = r_min_carry;
  assign day_pulse = r_day_pulse;

endmodule

// File: tb/tb_watch_time_counter.sv
// Bench for watch_time_counter: directed and random stimulus checked every cycle against
// a seconds-of-day reference model with a delayed-rising-edge view of the 1 Hz input.
module tb_watch_time_counter;
  localparam int S      = 2;
  localparam int INIT_T = 12 * 3600 + 34 * 60;
  localparam int HMAX   = 16384;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       clk1hz = 1'b0;
  logic       set_mode = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hour = 1'b0;
  logic [7:0] hh, mm, ss;
  logic       sec_tick, min_carry, day_pulse;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit eff_h [0:HMAX-1];
  bit rst_h [0:HMAX-1];
  int t_m    = 0;
  bit st_m, mc_m, dp_m;
  bit started = 1'b0;
  bit prev_tick = 1'b0;
  int n_tick_obs = 0;
  int n_day_obs  = 0;
  int n_coinc    = 0;
  int n_wide     = 0;

  always #10 CLOCK = ~CLOCK;

  watch_time_counter #(.SYNC_STAGES(S), .INIT_HH(8'h12), .INIT_MM(8'h34)) dut (
    .CLOCK(CLOCK), .RESET(RESET), ._1Hz_clk(clk1hz), .set_mode(set_mode),
    .inc_min(inc_min), .inc_hour(inc_hour), .hh(hh), .mm(mm), .ss(ss),
    .sec_tick(sec_tick), .min_carry(min_carry), .day_pulse(day_pulse));

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // A second elapses S edges after the first high sample that follows a low one,
  // unless a reset lands while that edge is still travelling through the synchronizer.
  function automatic bit model_tick(input int e);
    if (rst_h[e] || e < S + 1) return 1'b0;
    if (!eff_h[e-S] || eff_h[e-S-1]) return 1'b0;
    for (int j = e - S + 1; j < e; j++) if (rst_h[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    int h, m;
    @(posedge CLOCK);
    if (cyc >= HMAX) begin
      $display("FAIL cycle_budget: observed %0d expected below %0d", cyc, HMAX);
      $fatal(1, "cycle budget exhausted");
    end
    eff_h[cyc] = RESET ? 1'b0 : clk1hz;
    rst_h[cyc] = RESET;
    st_m = 1'b0; mc_m = 1'b0; dp_m = 1'b0;
    if (RESET) begin
      t_m = INIT_T;
      started = 1'b1;
    end else if (set_mode) begin
      h = t_m / 3600;
      m = (t_m / 60) % 60;
      if (inc_min)  m = (m + 1) % 60;
      if (inc_hour) h = (h + 1) % 24;
      t_m = h * 3600 + m * 60;
    end else if (model_tick(cyc)) begin
      st_m = 1'b1;
      mc_m = (t_m % 60 == 59);
      dp_m = (t_m == 86399);
      t_m  = (t_m + 1) % 86400;
    end
    cyc++;
    #1;
    if (started) begin
      chk("hh", 32'(hh), 32'(bcd(t_m / 3600)));
      chk("mm", 32'(mm), 32'(bcd((t_m / 60) % 60)));
      chk("ss", 32'(ss), 32'(bcd(t_m % 60)));
      chk("sec_tick", 32'(sec_tick), 32'(st_m));
      chk("min_carry", 32'(min_carry), 32'(mc_m));
      chk("day_pulse", 32'(day_pulse), 32'(dp_m));
      if (sec_tick === 1'b1) n_tick_obs++;
      if (sec_tick === 1'b1 && prev_tick) n_wide++;
      if (day_pulse === 1'b1) n_day_obs++;
      if (day_pulse === 1'b1 && min_carry === 1'b1) n_coinc++;
      prev_tick = (sec_tick === 1'b1);
    end
  endtask

  task automatic square(input int n, input int half);
    for (int p = 0; p < n; p++) begin
      clk1hz = 1'b0; repeat (half) step();
      clk1hz = 1'b1; repeat (half) step();
    end
    clk1hz = 1'b0;
    repeat (half) step();
  endtask

  initial begin
    int tick0, first_hi, first_tk, day0, co0;
    first_hi = -1;
    first_tk = -1;

    RESET = 1'b1;
    repeat (3) step();
    chk("rst_hh", 32'(hh), 32'h12);
    chk("rst_mm", 32'(mm), 32'h34);
    chk("rst_ss", 32'(ss), 32'h00);
    chk("rst_strobes", 32'({sec_tick, min_carry, day_pulse}), 32'd0);
    RESET = 1'b0;

    tick0 = n_tick_obs;
    for (int p = 0; p < 10; p++) begin
      clk1hz = 1'b0;
      repeat (4) step();
      clk1hz = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (first_hi < 0) first_hi = cyc;
        step();
        if (sec_tick === 1'b1 && first_tk < 0) first_tk = cyc - 1;
      end
    end
    clk1hz = 1'b0;
    repeat (4) step();
    chk("sq_ticks", 32'(n_tick_obs - tick0), 32'd10);
    chk("sq_latency", 32'(first_tk - first_hi), 32'(S));
    chk("sq_ss", 32'(ss), 32'h10);
    chk("sq_width", 32'(n_wide), 32'd0);

    set_mode = 1'b1;
    step();
    repeat (11) begin inc_hour = 1'b1; step(); inc_hour = 1'b0; step(); end
    repeat (25) begin inc_min = 1'b1; step(); inc_min = 1'b0; step(); end
    chk("set_2359", 32'({hh, mm, ss}), 32'h235900);
    set_mode = 1'b0;
    square(58, 3);
    chk("run_235958", 32'({hh, mm, ss}), 32'h235958);
    day0 = n_day_obs;
    co0  = n_coinc;
    square(1, 3);
    chk("run_235959", 32'({hh, mm, ss}), 32'h235959);
    square(1, 3);
    chk("run_000000", 32'({hh, mm, ss}), 32'h000000);
    chk("day_count", 32'(n_day_obs - day0), 32'd1);
    chk("day_with_carry", 32'(n_coinc - co0), 32'd1);

    set_mode = 1'b1;
    inc_hour = 1'b1;
    repeat (9) begin clk1hz = 1'($urandom_range(0, 1)); step(); end
    inc_hour = 1'b0;
    inc_min = 1'b1;
    repeat (59) begin clk1hz = 1'($urandom_range(0, 1)); step(); end
    inc_min = 1'b0;
    clk1hz = 1'b0;
    step();
    chk("set_0959", 32'({hh, mm, ss}), 32'h095900);
    inc_min = 1'b1; step(); inc_min = 1'b0; step();
    chk("set_min_wrap", 32'({hh, mm}), 32'h0900);
    repeat (15) begin inc_hour = 1'b1; step(); inc_hour = 1'b0; step(); end
    chk("set_hour_wrap", 32'(hh), 32'h00);
    inc_min = 1'b1; inc_hour = 1'b1; step();
    inc_min = 1'b0; inc_hour = 1'b0; step();
    chk("set_both", 32'({hh, mm}), 32'h0101);
    tick0 = n_tick_obs;
    square(3, 4);
    chk("set_frozen", 32'({hh, mm, ss}), 32'h010100);
    chk("set_no_ticks", 32'(n_tick_obs - tick0), 32'd0);
    set_mode = 1'b0;

    tick0 = n_tick_obs;
    clk1hz = 1'b1;
    repeat (50) step();
    clk1hz = 1'b0;
    repeat (5) step();
    chk("held_high_ticks", 32'(n_tick_obs - tick0), 32'd1);
    chk("held_high_ss", 32'({hh, mm, ss}), 32'h010101);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) clk1hz = ~clk1hz;
      if ($urandom_range(0, 63) == 0) set_mode = ~set_mode;
      inc_min  = ($urandom_range(0, 7) == 0);
      inc_hour = ($urandom_range(0, 7) == 0);
      RESET    = ($urandom_range(0, 199) == 0);
      step();
    end

    RESET = 1'b0; set_mode = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    square(5, 3);
    clk1hz = 1'b1;
    step();
    RESET = 1'b1;
    step();
    chk("midrst_digits", 32'({hh, mm, ss}), 32'h123400);
    chk("midrst_strobes", 32'({sec_tick, min_carry, day_pulse}), 32'd0);
    RESET = 1'b0;
    clk1hz = 1'b0;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/watch_time_counter.md
Name: watch_time_counter

Overview:
- Time-of-day core for the watch, directly downstream of the 1 Hz divider.
- Brings the divider's 1 Hz square wave into the CLOCK domain and detects its rising edge.
- Keeps BCD hours:minutes:seconds in 24 h format.
- Provides a set mode for the front-panel keys and feeds BCD digits and carry strobes to the display/alarm logic.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the _1Hz_clk synchronizer (≥2).
- INIT_HH, 8'h00, BCD hour loaded on reset (00–23).
- INIT_MM, 8'h00, BCD minute loaded on reset (00–59).

Ports:
- CLOCK  in  1  system clock (50 MHz), all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- _1Hz_clk  in  1  1 Hz square wave from the divider; a rising edge means one second elapsed.
- set_mode  in  1  1 = setting mode (time frozen), 0 = run.
- inc_min  in  1  single-cycle strobe: increment minutes (set mode only).
- inc_hour  in  1  single-cycle strobe: increment hours (set mode only).
- hh  out  8  BCD hours: [7:4] tens 0–2, [3:0] ones.
- mm  out  8  BCD minutes: [7:4] tens 0–5, [3:0] ones.
- ss  out  8  BCD seconds: [7:4] tens 0–5, [3:0] ones.
- sec_tick  out  1  one-cycle pulse when seconds advanced.
- min_carry  out  1  one-cycle pulse on the ss 59→00 rollover in run mode.
- day_pulse  out  1  one-cycle pulse on the 23:59:59→00:00:00 rollover.

Behaviour:
- Clock and reset: one clock (CLOCK). Reset (RESET) is synchronous and active-high, evaluated at the CLOCK posedge.
- Reset values:
  - hh=INIT_HH, mm=INIT_MM, ss=8'h00.
  - sec_tick, min_carry, day_pulse = 0.
  - All synchronizer flops and the edge-history flop = 0.
  - RESET overrides every other input in the same cycle.
- Synchronizer: _1Hz_clk passes through a SYNC_STAGES-deep flop chain, then an edge-history flop.
  - Internal tick = last sync stage AND NOT history.
  - Define edge 0 as the first posedge that samples _1Hz_clk high. Counters and sec_tick update at edge SYNC_STAGES.
  - Exactly one tick per low→high transition, regardless of high time.
  - A _1Hz_clk that is already high when RESET deasserts produces one tick. This is the decided behaviour.
- Run mode (set_mode=0), on tick:
  - ss increments in BCD. The ones digit wraps 9→0 with carry into tens; ss 59→00 carries into mm.
  - mm 59→00 carries into hh.
  - hh counts 00..23: the ones digit wraps 9→0 with carry into tens, except at 23, which rolls to 00.
  - sec_tick=1 for that one cycle. min_carry=1 when ss wrapped. day_pulse=1 when hh:mm:ss wrapped 23:59:59→00:00:00.
  - inc_min and inc_hour are ignored.
- Set mode (set_mode=1):
  - ss is forced to 00 every cycle; ticks are ignored; sec_tick, min_carry and day_pulse stay 0.
  - inc_min: mm += 1 mod 60 (59→00), no carry into hh.
  - inc_hour: hh += 1 mod 24 (23→00).
  - Both strobes in the same cycle are applied independently.
  - A strobe held high increments every cycle; upstream delivers single-cycle pulses.
- Mode transitions:
  - set→run: counting resumes from hh:mm:00 on the next tick.
  - run→set: takes effect the same cycle and discards any tick in that cycle.
- Outputs: all registered, no combinational path from input to output. Digits are always legal BCD in range.
- Strobes: sec_tick, min_carry and day_pulse are each exactly one CLOCK cycle wide and coincide with the digit update.

Test Plan:
- Reset with INIT_HH=8'h12, INIT_MM=8'h34; RESET high for 3 cycles, _1Hz_clk=0 → hh=12, mm=34, ss=00, all strobes 0.
- Drive _1Hz_clk as a square wave, 4 cycles low / 4 cycles high, for 10 periods.
  - ss steps 00→10 in BCD (09→10 at the 10th).
  - Exactly 10 sec_tick pulses, each one cycle wide.
  - First update occurs at edge SYNC_STAGES after the first high sample.
- Start at 23:59:58 (via set mode, then run) and apply 2 ticks → 23:59:59, then 00:00:00.
  - On the second tick: min_carry=1 and day_pulse=1 in the same cycle.
- Set mode with time 09:59:xx:
  - ss forced to 00.
  - inc_min ×1 → mm=00, hh stays 09.
  - inc_hour ×15 → hh=00 (wraps 23→00).
  - inc_min and inc_hour in the same cycle → mm=01, hh=01.
  - Ticks during set mode change nothing.
- _1Hz_clk held high 50 cycles, then low → exactly one tick. RESET asserted in the middle of a count → digits return to INIT values next cycle, strobes 0.
